user_position: RTL and testbench

//   Cursor/user position register for the pixel-art canvas. Integrates the

---
 rtl/user_position_if.sv | 25 ++
 rtl/user_position.sv | 99 +++++++++
 tb/tb_user_position.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/user_position_if.sv
// Direction inputs and cursor position bundle between button conditioning,
// the position register and the canvas/VGA renderer.
interface user_position_if #(
  parameter int X_W = 6,
  parameter int Y_W = 5
);
  logic           left;
  logic           right;
  logic           up;
  logic           down;
  logic [X_W-1:0] userX;
  logic [Y_W-1:0] userY;

  // Driver side: buttons in, cursor position back.
  modport master (
    output left, right, up, down,
    input  userX, userY
  );

  // Position register side.
  modport slave (
    input  left, right, up, down,
    output userX, userY
  );
endinterface

// File: rtl/user_position.sv
// Cursor position register: integrates up/down/left/right into a wrapping X/Y
// grid coordinate. Define USER_POSITION_EDGE_MOVE_EN for one step per press.
module user_position #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 32,
  parameter int X_W     = 6,
  parameter int Y_W     = 5,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  user_position_if.slave bus
);
  localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X_START = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);
  localparam logic [X_W-1:0] X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE   = Y_W'(1);

  // Bit order of the direction vector: {left, right, up, down}.
  localparam int DIR_LEFT  = 3;
  localparam int DIR_RIGHT = 2;
  localparam int DIR_UP    = 1;
  localparam int DIR_DOWN  = 0;

  logic [3:0]     w_dir;
  logic [3:0]     w_step;
  logic           w_x_inc;
  logic           w_x_dec;
  logic           w_y_inc;
  logic           w_y_dec;
  logic [X_W-1:0] w_x_next;
  logic [Y_W-1:0] w_y_next;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;

  assign w_dir = {bus.left, bus.right, bus.up, bus.down};

`ifdef USER_POSITION_EDGE_MOVE_EN
  logic [3:0] r_hist;

  // One history flop per direction; a step fires only on a 0->1 transition.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hist
      always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
          r_hist[gi] <= 1'b0;
        end else begin
          r_hist[gi] <= w_dir[gi];
        end
      end
    end
  endgenerate

  assign w_step = w_dir & ~r_hist;
`else
  assign w_step = w_dir;
`endif

  // Opposing requests on the same axis cancel.
  assign w_x_inc = w_step[DIR_RIGHT] & ~w_step[DIR_LEFT];
  assign w_x_dec = w_step[DIR_LEFT]  & ~w_step[DIR_RIGHT];
  assign w_y_inc = w_step[DIR_DOWN]  & ~w_step[DIR_UP];
  assign w_y_dec = w_step[DIR_UP]    & ~w_step[DIR_DOWN];

  // Explicit edge compares so non-power-of-two grids wrap correctly.
  always_comb begin
    w_x_next = r_x;
    if (w_x_inc) begin
      w_x_next = (r_x == X_MAX) ? '0 : r_x + X_ONE;
    end else if (w_x_dec) begin
      w_x_next = (r_x == '0) ? X_MAX : r_x - X_ONE;
    end
  end

  always_comb begin
    w_y_next = r_y;
    if (w_y_inc) begin
      w_y_next = (r_y == Y_MAX) ? '0 : r_y + Y_ONE;
    end else if (w_y_dec) begin
      w_y_next = (r_y == '0) ? Y_MAX : r_y - Y_ONE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_x <= X_START;
      r_y <= Y_START;
    end else begin
      r_x <= w_x_next;
      r_y <= w_y_next;
    end
  end

  assign bus.userX = r_x;
  assign bus.userY = r_y;
endmodule

// File: tb/tb_user_position.sv
// Directed bench for user_position: reset, stepping, wrap, cancel, diagonal
// and asynchronous reset; a separate sequence covers the edge-move build.
`timescale 1ns/1ps
module tb_user_position;
  localparam int X_W = 6;
  localparam int Y_W = 5;

  logic CLOCK_50;
  logic reset;
  int   n_checks;
  int   n_errors;

  user_position_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  user_position #(
    .GRID_W(64), .GRID_H(32), .X_W(X_W), .Y_W(Y_W), .START_X(0), .START_Y(0)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock and land 1ns after the active edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_dir(input logic l, input logic r, input logic u, input logic d);
    bus.left  = l;
    bus.right = r;
    bus.up    = u;
    bus.down  = d;
  endtask

  initial begin
    int exp_x [5];
    int exp_y [6];
    n_checks = 0;
    n_errors = 0;
    set_dir(0, 0, 0, 0);
    reset = 1'b0;

    tick();
    chk("reset_x", int'(bus.userX), 0);
    chk("reset_y", int'(bus.userY), 0);
    #2 reset = 1'b1;
    tick();
    chk("idle_x", int'(bus.userX), 0);

`ifndef USER_POSITION_EDGE_MOVE_EN
    set_dir(0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("right_%0d", i), int'(bus.userX), i);
    end
    set_dir(0, 0, 0, 0);
    tick();
    chk("right_hold_x", int'(bus.userX), 4);
    chk("right_hold_y", int'(bus.userY), 0);

    set_dir(0, 0, 0, 1);
    repeat (4) tick();
    chk("down4_y", int'(bus.userY), 4);
    chk("down4_x", int'(bus.userX), 4);

    exp_x = '{3, 2, 1, 0, 63};
    set_dir(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("left_%0d", i), int'(bus.userX), exp_x[i]);
    end

    exp_y = '{3, 2, 1, 0, 31, 30};
    set_dir(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("up_%0d", i), int'(bus.userY), exp_y[i]);
    end
    chk("up_x_still", int'(bus.userX), 63);

    set_dir(1, 1, 1, 1);
    repeat (3) tick();
    chk("cancel_x", int'(bus.userX), 63);
    chk("cancel_y", int'(bus.userY), 30);

    set_dir(0, 1, 0, 1);
    tick();
    chk("diag_x_wrap", int'(bus.userX), 0);
    chk("diag_y", int'(bus.userY), 31);
    set_dir(0, 0, 0, 1);
    tick();
    chk("down_wrap_y", int'(bus.userY), 0);

    set_dir(0, 1, 0, 0);
    repeat (2) tick();
    chk("pre_rst_x", int'(bus.userX), 2);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_x", int'(bus.userX), 0);
    chk("async_rst_y", int'(bus.userY), 0);
    repeat (2) tick();
    chk("rst_held_x", int'(bus.userX), 0);
    #3 reset = 1'b1;
    tick();
    chk("resume_x", int'(bus.userX), 1);
    set_dir(0, 0, 0, 0);
`else
    set_dir(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("edge_right_%0d", i), int'(bus.userX), 1);
    end
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(0, 1, 0, 0);
    tick();
    chk("edge_repress_x", int'(bus.userX), 2);
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(1, 1, 0, 0);
    tick();
    chk("edge_cancel_x", int'(bus.userX), 2);
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(1, 0, 1, 0);
    tick();
    chk("edge_diag_x", int'(bus.userX), 1);
    chk("edge_up_wrap_y", int'(bus.userY), 31);
    repeat (3) tick();
    chk("edge_held_y", int'(bus.userY), 31);
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(0, 0, 0, 1);
    tick();
    chk("edge_down_wrap_y", int'(bus.userY), 0);
    #3 reset = 1'b0;
    #1;
    chk("edge_async_rst_x", int'(bus.userX), 0);
    set_dir(0, 0, 0, 0);
    #3 reset = 1'b1;
    tick();
    chk("edge_resume_x", int'(bus.userX), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
